// File: rtl/jk_toggle_tracker_if.sv
// Signal bundle between the JK flip-flop side (master) and the toggle tracker (slave).
interface jk_toggle_tracker_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = 8
);
    logic             en;
    logic             y;
    logic             clr_cnt;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] toggle_cnt;
    logic             cnt_sat;
    logic [LEN_W-1:0] high_len;
    logic             high_len_vld;
    logic             stuck;

    modport master (
        output en, y, clr_cnt,
        input  rise, fall, toggle_cnt, cnt_sat, high_len, high_len_vld, stuck
    );

    modport slave (
        input  en, y, clr_cnt,
        output rise, fall, toggle_cnt, cnt_sat, high_len, high_len_vld, stuck
    );
endinterface

// File: rtl/jk_toggle_tracker.sv
// Monitors the JK flip-flop output: edge pulses, saturating toggle count,
// last completed high-period length and a stuck-level flag.
module jk_toggle_tracker #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned STABLE_MAX = 16
) (
    input logic                clk,
    input logic                reset,
    jk_toggle_tracker_if.slave bus
);
    localparam int unsigned    StW       = $clog2(STABLE_MAX + 1);
    localparam logic [StW-1:0] StableMax = StW'(STABLE_MAX);
    localparam logic [StW-1:0] StableOne = StW'(1);
    localparam logic [LEN_W-1:0] RunMax  = '1;
    localparam logic [LEN_W-1:0] RunOne  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {StInit, StLow, StHigh} state_e;

    state_e           state_q, state_d;
    logic [StW-1:0]   stable_q, stable_d;
    logic [LEN_W-1:0] run_q, run_d;
    logic [LEN_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             vld_q, vld_d;
    logic             stuck_q, stuck_d;
    logic [StW-1:0]   stable_inc;
    logic [LEN_W-1:0] run_inc;

    assign stable_inc = (stable_q == StableMax) ? stable_q : stable_q + StableOne;
    assign run_inc    = (run_q == RunMax) ? run_q : run_q + RunOne;

    // Next-state: level tracking, run counters, pulses and toggle count
    always_comb begin
        state_d    = state_q;
        stable_d   = stable_q;
        run_d      = run_q;
        high_len_d = high_len_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        vld_d      = 1'b0;
        stuck_d    = stuck_q;

        if (bus.en) begin
            unique case (state_q)
                StInit: begin
                    state_d  = bus.y ? StHigh : StLow;
                    stable_d = StableOne;
                    run_d    = bus.y ? RunOne : '0;
                end
                StLow: begin
                    if (bus.y) begin
                        state_d  = StHigh;
                        rise_d   = 1'b1;
                        stable_d = StableOne;
                        run_d    = RunOne;
                    end else begin
                        stable_d = stable_inc;
                    end
                end
                StHigh: begin
                    if (!bus.y) begin
                        state_d    = StLow;
                        fall_d     = 1'b1;
                        high_len_d = run_q;
                        vld_d      = 1'b1;
                        stable_d   = StableOne;
                    end else begin
                        stable_d = stable_inc;
                        run_d    = run_inc;
                    end
                end
                default: state_d = StInit;
            endcase

            // The first sample after init never counts as stuck
            stuck_d = (state_q != StInit) && (stable_d == StableMax);

            if ((rise_d || fall_d) && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            sat_d = sat_q | (cnt_d == CntMax);
        end

        // Clear wins over a same-cycle increment and works while frozen
        if (bus.clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StInit;
            stable_q   <= '0;
            run_q      <= '0;
            high_len_q <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            vld_q      <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stable_q   <= stable_d;
            run_q      <= run_d;
            high_len_q <= high_len_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            vld_q      <= vld_d;
            stuck_q    <= stuck_d;
        end
    end

    assign bus.rise         = rise_q;
    assign bus.fall         = fall_q;
    assign bus.toggle_cnt   = cnt_q;
    assign bus.cnt_sat      = sat_q;
    assign bus.high_len     = high_len_q;
    assign bus.high_len_vld = vld_q;
    assign bus.stuck        = stuck_q;
endmodule

// File: tb/tb_jk_toggle_tracker.sv
// Scoreboard bench for jk_toggle_tracker: the driver queues the expected outputs
// for the cycle after each stimulus; a monitor compares them on the falling edge.
module tb_jk_toggle_tracker;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned STABLE_MAX = 16;
    localparam int          X          = -1;  // don't care

    logic clk = 1'b0;
    logic reset;

    jk_toggle_tracker_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    jk_toggle_tracker #(
        .CNT_W     (CNT_W),
        .LEN_W     (LEN_W),
        .STABLE_MAX(STABLE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    due;
        int    rise;
        int    fall;
        int    vld;
        int    len;
        int    cnt;
        int    sat;
        int    stuck;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input string field, input int act, input int req);
        if (req >= 0) begin
            checks++;
            if (act != req) begin
                failures++;
                $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)",
                         name, field, act, req, cyc);
            end
        end
    endtask

    task automatic pop_and_compare();
        exp_t e;
        e = sb.pop_front();
        if (e.due != cyc) begin
            checks++;
            failures++;
            $display("FAIL %s.schedule actual=%0d required=%0d", e.name, cyc, e.due);
        end else begin
            chk(e.name, "rise",         int'(bus.rise),         e.rise);
            chk(e.name, "fall",         int'(bus.fall),         e.fall);
            chk(e.name, "high_len_vld", int'(bus.high_len_vld), e.vld);
            chk(e.name, "high_len",     int'(bus.high_len),     e.len);
            chk(e.name, "toggle_cnt",   int'(bus.toggle_cnt),   e.cnt);
            chk(e.name, "cnt_sat",      int'(bus.cnt_sat),      e.sat);
            chk(e.name, "stuck",        int'(bus.stuck),        e.stuck);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare whatever is due
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) pop_and_compare();
        end
    end

    task automatic step(input bit rst_n, input bit en, input bit y, input bit clr,
                        input string name, input int er, input int ef, input int ev,
                        input int el, input int ec, input int es, input int est);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst_n;
        bus.en      = en;
        bus.y       = y;
        bus.clr_cnt = clr;
        e = '{name: name, due: cyc + 1, rise: er, fall: ef, vld: ev, len: el,
              cnt: ec, sat: es, stuck: est};
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit yv;
        reset       = 1'b0;
        bus.en      = 1'b0;
        bus.y       = 1'b0;
        bus.clr_cnt = 1'b0;

        // Reset with y=1, release: init goes high without reporting an edge
        step(0, 1, 1, 0, "rst_a",         0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, "rst_b",         0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, "init_high",     0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, "init_was_high", 0, 1, 1, 1, 1, 0, 0);
        step(1, 1, 0, 1, "clr_in_low",    0, 0, 0, 1, 0, 0, 0);

        // Three-sample high pulse from S_LOW
        step(1, 1, 1, 0, "s2_rise",   1, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0, "s2_hold_a", 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0, "s2_hold_b", 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0, "s2_fall",   0, 1, 1, 3, 2, 0, 0);
        step(1, 1, 0, 0, "s2_low",    0, 0, 0, 3, 2, 0, 0);

        // Low level sampled 16 times in total -> stuck on the 16th sample
        for (int k = 3; k <= 16; k++) begin
            step(1, 1, 0, 0, "s4_hold", 0, 0, 0, 3, 2, 0, (k == 16) ? 1 : 0);
        end
        step(1, 1, 0, 0, "s4_still_stuck", 0, 0, 0, 3, 2, 0, 1);
        step(1, 1, 1, 0, "s4_rise_clears", 1, 0, 0, 3, 3, 0, 0);

        // Freeze while y toggles; resume compares to the pre-freeze high level
        for (int i = 0; i < 4; i++) begin
            yv = (i % 2) == 1;
            step(1, 0, yv, 0, "s5_frozen", 0, 0, 0, 3, 3, 0, 0);
        end
        step(1, 1, 1, 0, "s5_resume", 0, 0, 0, 3, 3, 0, 0);
        step(1, 1, 0, 0, "s5_fall",   0, 1, 1, 2, 4, 0, 0);

        // Clear while frozen, clear overriding an edge count
        step(1, 0, 1, 1, "clr_frozen",     0, 0, 0, 2, 0, 0, 0);
        step(1, 1, 1, 1, "clr_over_rise",  1, 0, 0, 2, 0, 0, 0);
        step(1, 1, 0, 0, "fall_after_clr", 0, 1, 1, 1, 1, 0, 0);

        // 300 toggles: count saturates at 255 and sets cnt_sat
        step(1, 1, 0, 1, "s3_clr", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            yv = (i % 2) == 1;
            step(1, 1, yv, 0, "s3_toggle", yv ? 1 : 0, yv ? 0 : 1, yv ? 0 : 1, 1,
                 (i < 255) ? i : 255, (i >= 255) ? 1 : 0, 0);
        end
        step(1, 1, 0, 1, "s3_clr_after", 0, 0, 0, 1, 0, 0, 0);

        // Reset in the middle of a 5-sample high run; that run is never reported
        step(1, 1, 1, 0, "s6_rise", 1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 0, "s6_run", 0, 0, 0, 1, 1, 0, 0);
        end
        step(0, 1, 1, 0, "s6_reset",    0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, "s6_init_low", 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, "s6_low",      0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
